cpu_runctl: RTL and testbench
=============================

# cpu_runctl

Run/step/breakpoint controller that sequences the 4-phase CPU (fetch, exec, mem, writeback). It produces the CPU clock-enable `cpu_en`, tracks the CPU phase with its own counter, and halts on a PC breakpoint at an instruction boundary. It keeps cycle and instruction counters for the debug/test display. It sits between the board's debug inputs and the CPU core, and the top level gates CPU state updates with `cpu_en`.

## Interface
- `WIDTH`, 32, width of the PC, breakpoint address and counters.
- `clk`  in  1  system clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high; also resets the CPU, so the CPU is at fetch when it releases.
- `run_req`  in  1  level-sampled; enter free-running mode.
- `stop_req`  in  1  level-sampled; stop execution.
- `cstep_req`  in  1  level-sampled; execute exactly one CPU clock cycle (one phase).
- `istep_req`  in  1  level-sampled; execute until the current/next instruction completes.
- `brk_en`  in  1  breakpoint enable.
- `brk_addr`  in  WIDTH  breakpoint PC value.
- `pc`  in  WIDTH  current CPU PC (R15).
- `cpu_en`  out  1  combinational; CPU advances one phase on each posedge where `cpu_en`=1.
- `ph_cnt`  out  2  registered; CPU phase about to execute (0=fetch, 1=exec, 2=mem, 3=writeback).
- `running`  out  1  registered; state is RUN, CSTEP or ISTEP.
- `at_brk`  out  1  registered; state is BRK.
- `cycle_cnt`  out  WIDTH  registered; number of enabled CPU cycles.
- `instr_cnt`  out  WIDTH  registered; number of completed instructions.

## Operation
- **States:** IDLE, RUN, CSTEP, ISTEP, BRK. Encoding is free.
- **Internal flag `skip`:** suppresses the breakpoint check for the first instruction after entering RUN.
- **Breakpoint hit:** `hit` = `brk_en` & (`ph_cnt`==0) & (`pc`==`brk_addr`) & ~`skip`.
- **`cpu_en`:**
  - RUN: ~`hit`.
  - CSTEP, ISTEP: 1.
  - IDLE, BRK: 0.
- **Request priority**, evaluated each edge: stop > istep > cstep > run.
- **IDLE or BRK:**
  - stop → IDLE.
  - istep → ISTEP.
  - cstep → CSTEP.
  - run → RUN, and set `skip`=1.
- **RUN:**
  - stop → IDLE.
  - `hit` → BRK.
  - Step requests and `run_req` are ignored.
- **CSTEP:** always → IDLE after its single enabled cycle. Requests are ignored.
- **ISTEP:**
  - If the enabled cycle has `ph_cnt`==3 → IDLE.
  - stop → IDLE; the instruction is left mid-phase and later resumes from the same `ph_cnt`.
  - Other requests are ignored.
  - Breakpoints are not checked in CSTEP or ISTEP.
- **`skip`:** cleared on the first edge with `cpu_en`=1 in RUN.
- **`ph_cnt`:** increments mod 4 on every edge with `cpu_en`=1; it is never modified otherwise.
- **`cycle_cnt`:** +1 on every edge with `cpu_en`=1.
- **`instr_cnt`:** +1 on edges with `cpu_en`=1 and `ph_cnt`==3.
- **Counters:** both wrap from 2^WIDTH−1 to 0 with no flag.

## Timing
- **Reset values:** state IDLE, `ph_cnt`=0, `skip`=0, `cycle_cnt`=0, `instr_cnt`=0, `running`=0, `at_brk`=0, `cpu_en`=0.
- **Request latency:** a request sampled at edge N changes the state at N. `cpu_en` reflects the new state in cycle N+1. A request never affects `cpu_en` in the cycle it is asserted.
- **RUN:** one CPU phase per clock; an instruction takes 4 clocks.
- **ISTEP from `ph_cnt`=k:** exactly 4−k enabled cycles, then IDLE.
- **Breakpoint:** `hit` is evaluated only at `ph_cnt`==0, after the previous writeback edge, so `pc` is final. `cpu_en` drops in the same cycle and BRK is entered at the next edge. The fetch at `brk_addr` is not performed.
- **Simultaneous stop and `hit` in RUN:** goes to IDLE; `at_brk` stays 0.
- **Reset mid-instruction:** returns everything to its reset values asynchronously; the CPU is reset together with this block.

## Test plan
- **Reset, then idle:** after reset, hold all requests low for 20 cycles → `cpu_en`=0 throughout, `cycle_cnt`=0, `ph_cnt`=0.
- **Run then stop:** run_req 1 cycle, then stop_req after 10 cycles → exactly 10 enabled cycles, `cycle_cnt`=10, `instr_cnt`=2, `ph_cnt`=2, state IDLE.
- **Single steps:** 3 cstep pulses, then 1 istep pulse → `ph_cnt` 0→1→2→3, then istep gives 1 enabled cycle; `instr_cnt`=1, `cycle_cnt`=4.
- **Breakpoint:** `brk_en`=1, `brk_addr`=3, code of sequential NOPs from 0, run_req → BRK entered with `pc`=3, `instr_cnt`=3, `at_brk`=1. Then run_req → execution continues past address 3 (`skip`); `instr_cnt`=4 after 4 more cycles.
- **Priority:** stop_req and istep_req asserted together in IDLE → stays IDLE. istep_req and run_req together → ISTEP, run_req is ignored.
- **Wrap and async reset:** WIDTH=4 instance, run 17 cycles → `cycle_cnt`=1 (wrapped). Assert reset mid-cycle in RUN → all outputs zero immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_runctl_if.sv
// Debug-side bundle for the CPU run controller: run/step/breakpoint requests
// and the CPU PC going in; clock enable, phase and counters coming out.
interface cpu_runctl_if #(
  parameter int WIDTH = 32
);
  logic             run_req;
  logic             stop_req;
  logic             cstep_req;
  logic             istep_req;
  logic             brk_en;
  logic [WIDTH-1:0] brk_addr;
  logic [WIDTH-1:0] pc;
  logic             cpu_en;
  logic [1:0]       ph_cnt;
  logic             running;
  logic             at_brk;
  logic [WIDTH-1:0] cycle_cnt;
  logic [WIDTH-1:0] instr_cnt;

  // Debug/board side: issues requests, observes the controller.
  modport master (
    output run_req, stop_req, cstep_req, istep_req, brk_en, brk_addr, pc,
    input  cpu_en, ph_cnt, running, at_brk, cycle_cnt, instr_cnt
  );

  // Controller side.
  modport slave (
    input  run_req, stop_req, cstep_req, istep_req, brk_en, brk_addr, pc,
    output cpu_en, ph_cnt, running, at_brk, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/cpu_runctl.sv
// Run/step/breakpoint controller for a 4-phase CPU. Generates the CPU clock
// enable, tracks the phase, halts at a PC breakpoint on an instruction
// boundary and counts enabled cycles and completed instructions.
module cpu_runctl #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  cpu_runctl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CSTEP,
    S_ISTEP,
    S_BRK
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ph_q, ph_d;
  logic             skip_q, skip_d;
  logic [WIDTH-1:0] cyc_q, cyc_d;
  logic [WIDTH-1:0] ins_q, ins_d;
  logic             running_q, running_d;
  logic             at_brk_q, at_brk_d;
  logic             hit;
  logic             cpu_en;

  // Next-state, clock enable, phase and counter updates.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; a missed branch would otherwise infer a latch.
    state_d = state_q;
    ph_d    = ph_q;
    skip_d  = skip_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    cpu_en  = 1'b0;

    // Breakpoint only at fetch, once the previous writeback has settled pc;
    // skip lets RUN step off the address it just stopped at.
    hit = bus.brk_en && (ph_q == 2'd0) && (bus.pc == bus.brk_addr) && !skip_q;

    unique case (state_q)
      S_IDLE, S_BRK: begin
        if (bus.stop_req)       state_d = S_IDLE;
        else if (bus.istep_req) state_d = S_ISTEP;
        else if (bus.cstep_req) state_d = S_CSTEP;
        else if (bus.run_req) begin
          state_d = S_RUN;
          skip_d  = 1'b1;
        end
      end
      S_RUN: begin
        cpu_en = !hit;
        if (cpu_en) skip_d = 1'b0;
        if (bus.stop_req) state_d = S_IDLE;
        else if (hit)     state_d = S_BRK;
      end
      S_CSTEP: begin
        cpu_en  = 1'b1;
        state_d = S_IDLE;
      end
      S_ISTEP: begin
        cpu_en = 1'b1;
        // Stop may leave the instruction mid-way; ph_cnt keeps its place.
        if (ph_q == 2'd3 || bus.stop_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cpu_en) begin
      ph_d  = ph_q + 2'd1;
      cyc_d = cyc_q + WIDTH'(1);
      if (ph_q == 2'd3) ins_d = ins_q + WIDTH'(1);
    end

    running_d = (state_d == S_RUN) || (state_d == S_CSTEP) || (state_d == S_ISTEP);
    at_brk_d  = (state_d == S_BRK);
  end

  // State and counter registers, cleared asynchronously with the CPU.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      ph_q      <= 2'd0;
      skip_q    <= 1'b0;
      cyc_q     <= '0;
      ins_q     <= '0;
      running_q <= 1'b0;
      at_brk_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      skip_q    <= skip_d;
      cyc_q     <= cyc_d;
      ins_q     <= ins_d;
      running_q <= running_d;
      at_brk_q  <= at_brk_d;
    end
  end

  assign bus.cpu_en    = cpu_en;
  assign bus.ph_cnt    = ph_q;
  assign bus.running   = running_q;
  assign bus.at_brk    = at_brk_q;
  assign bus.cycle_cnt = cyc_q;
  assign bus.instr_cnt = ins_q;

endmodule

// File: tb/tb_cpu_runctl.sv
// Directed bench for cpu_runctl: reset/idle, run/stop, stepping, breakpoints,
// request priority, counter wrap and asynchronous reset.
module tb_cpu_runctl;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  cpu_runctl_if #(.WIDTH(32)) bus ();
  cpu_runctl_if #(.WIDTH(4))  b4 ();

  cpu_runctl #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  cpu_runctl #(.WIDTH(4))  dut4 (.clk(clk), .reset(reset), .bus(b4));

  // CPU stand-in running sequential NOPs: pc advances at each writeback.
  logic [31:0] pc_model;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_model <= '0;
    else if (bus.cpu_en && bus.ph_cnt == 2'd3) pc_model <= pc_model + 32'd1;
  end
  assign bus.pc = pc_model;
  assign b4.pc  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.cpu_en !== 1'b0) $display("FAIL rst_cpu_en: got %0b want 0", bus.cpu_en); else passed++;
    checks++; if (bus.running !== 1'b0) $display("FAIL rst_running: got %0b want 0", bus.running); else passed++;
    checks++; if (bus.at_brk !== 1'b0) $display("FAIL rst_at_brk: got %0b want 0", bus.at_brk); else passed++;
    checks++; if (bus.instr_cnt !== 32'd0) $display("FAIL rst_instr: got %0d want 0", bus.instr_cnt); else passed++;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if (bus.cpu_en !== 1'b0) $display("FAIL idle_cpu_en cyc%0d: got %0b want 0", i, bus.cpu_en); else passed++;
    end
    checks++; if (bus.cycle_cnt !== 32'd0) $display("FAIL idle_cycle: got %0d want 0", bus.cycle_cnt); else passed++;
    checks++; if (bus.ph_cnt !== 2'd0) $display("FAIL idle_ph: got %0d want 0", bus.ph_cnt); else passed++;
  endtask

  task automatic test_run_stop();
    do_reset();
    bus.run_req = 1'b1;
    #1;
    checks++; if (bus.cpu_en !== 1'b0) $display("FAIL run_latency: got %0b want 0", bus.cpu_en); else passed++;
    tick();
    bus.run_req = 1'b0;
    checks++; if (bus.running !== 1'b1) $display("FAIL run_enter: got %0b want 1", bus.running); else passed++;
    checks++; if (bus.cpu_en !== 1'b1) $display("FAIL run_cpu_en: got %0b want 1", bus.cpu_en); else passed++;
    repeat (9) tick();
    bus.stop_req = 1'b1;
    tick();
    bus.stop_req = 1'b0;
    checks++; if (bus.cycle_cnt !== 32'd10) $display("FAIL runstop_cycle: got %0d want 10", bus.cycle_cnt); else passed++;
    checks++; if (bus.instr_cnt !== 32'd2) $display("FAIL runstop_instr: got %0d want 2", bus.instr_cnt); else passed++;
    checks++; if (bus.ph_cnt !== 2'd2) $display("FAIL runstop_ph: got %0d want 2", bus.ph_cnt); else passed++;
    checks++; if (bus.running !== 1'b0) $display("FAIL runstop_running: got %0b want 0", bus.running); else passed++;
    checks++; if (bus.cpu_en !== 1'b0) $display("FAIL runstop_cpu_en: got %0b want 0", bus.cpu_en); else passed++;
    tick();
    checks++; if (bus.cycle_cnt !== 32'd10) $display("FAIL runstop_hold: got %0d want 10", bus.cycle_cnt); else passed++;
  endtask

  task automatic test_single_steps();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.cstep_req = 1'b1;
      tick();
      bus.cstep_req = 1'b0;
      checks++; if (bus.cpu_en !== 1'b1) $display("FAIL cstep_en%0d: got %0b want 1", i, bus.cpu_en); else passed++;
      tick();
      checks++; if (bus.ph_cnt !== 2'(i + 1)) $display("FAIL cstep_ph%0d: got %0d want %0d", i, bus.ph_cnt, i + 1); else passed++;
      checks++; if (bus.running !== 1'b0) $display("FAIL cstep_idle%0d: got %0b want 0", i, bus.running); else passed++;
    end
    bus.istep_req = 1'b1;
    tick();
    bus.istep_req = 1'b0;
    tick();
    checks++; if (bus.ph_cnt !== 2'd0) $display("FAIL istep_ph: got %0d want 0", bus.ph_cnt); else passed++;
    checks++; if (bus.instr_cnt !== 32'd1) $display("FAIL istep_instr: got %0d want 1", bus.instr_cnt); else passed++;
    checks++; if (bus.cycle_cnt !== 32'd4) $display("FAIL istep_cycle: got %0d want 4", bus.cycle_cnt); else passed++;
    checks++; if (bus.running !== 1'b0) $display("FAIL istep_idle: got %0b want 0", bus.running); else passed++;
    tick();
    checks++; if (bus.cycle_cnt !== 32'd4) $display("FAIL istep_hold: got %0d want 4", bus.cycle_cnt); else passed++;
  endtask

  task automatic test_istep_stop();
    do_reset();
    bus.istep_req = 1'b1;
    tick();
    bus.istep_req = 1'b0;
    tick();
    bus.stop_req = 1'b1;
    tick();
    bus.stop_req = 1'b0;
    checks++; if (bus.ph_cnt !== 2'd2) $display("FAIL istop_ph: got %0d want 2", bus.ph_cnt); else passed++;
    checks++; if (bus.running !== 1'b0) $display("FAIL istop_idle: got %0b want 0", bus.running); else passed++;
    tick();
    checks++; if (bus.cycle_cnt !== 32'd2) $display("FAIL istop_cycle: got %0d want 2", bus.cycle_cnt); else passed++;
    bus.istep_req = 1'b1;
    tick();
    bus.istep_req = 1'b0;
    tick();
    tick();
    checks++; if (bus.ph_cnt !== 2'd0) $display("FAIL iresume_ph: got %0d want 0", bus.ph_cnt); else passed++;
    checks++; if (bus.instr_cnt !== 32'd1) $display("FAIL iresume_instr: got %0d want 1", bus.instr_cnt); else passed++;
    checks++; if (bus.cycle_cnt !== 32'd4) $display("FAIL iresume_cycle: got %0d want 4", bus.cycle_cnt); else passed++;
    checks++; if (bus.running !== 1'b0) $display("FAIL iresume_idle: got %0b want 0", bus.running); else passed++;
  endtask

  task automatic test_breakpoint();
    int n;
    do_reset();
    bus.brk_en   = 1'b1;
    bus.brk_addr = 32'd3;
    bus.run_req  = 1'b1;
    tick();
    bus.run_req = 1'b0;
    n = 0;
    while (!(bus.running && !bus.cpu_en) && n < 60) begin
      tick();
      n++;
    end
    checks++; if (n >= 60) $display("FAIL brk_timeout: got %0d cycles want < 60", n); else passed++;
    checks++; if (pc_model !== 32'd3) $display("FAIL brk_pc: got %0d want 3", pc_model); else passed++;
    checks++; if (bus.instr_cnt !== 32'd3) $display("FAIL brk_instr: got %0d want 3", bus.instr_cnt); else passed++;
    checks++; if (bus.cycle_cnt !== 32'd12) $display("FAIL brk_cycle: got %0d want 12", bus.cycle_cnt); else passed++;
    checks++; if (bus.ph_cnt !== 2'd0) $display("FAIL brk_ph: got %0d want 0", bus.ph_cnt); else passed++;
    tick();
    checks++; if (bus.at_brk !== 1'b1) $display("FAIL brk_at_brk: got %0b want 1", bus.at_brk); else passed++;
    checks++; if (bus.running !== 1'b0) $display("FAIL brk_running: got %0b want 0", bus.running); else passed++;
    tick();
    checks++; if (bus.cycle_cnt !== 32'd12) $display("FAIL brk_hold: got %0d want 12", bus.cycle_cnt); else passed++;
    bus.run_req = 1'b1;
    tick();
    bus.run_req = 1'b0;
    checks++; if (bus.at_brk !== 1'b0) $display("FAIL brk_leave: got %0b want 0", bus.at_brk); else passed++;
    checks++; if (bus.cpu_en !== 1'b1) $display("FAIL brk_skip_en: got %0b want 1", bus.cpu_en); else passed++;
    repeat (4) tick();
    checks++; if (bus.instr_cnt !== 32'd4) $display("FAIL brk_resume_instr: got %0d want 4", bus.instr_cnt); else passed++;
    checks++; if (pc_model !== 32'd4) $display("FAIL brk_resume_pc: got %0d want 4", pc_model); else passed++;
    bus.stop_req = 1'b1;
    tick();
    bus.stop_req = 1'b0;
    bus.brk_en   = 1'b0;
  endtask

  task automatic test_stop_and_hit();
    int n;
    do_reset();
    bus.brk_en   = 1'b1;
    bus.brk_addr = 32'd1;
    bus.run_req  = 1'b1;
    tick();
    bus.run_req = 1'b0;
    n = 0;
    while (!(bus.running && !bus.cpu_en) && n < 60) begin
      tick();
      n++;
    end
    checks++; if (n >= 60) $display("FAIL sh_timeout: got %0d cycles want < 60", n); else passed++;
    bus.stop_req = 1'b1;
    tick();
    bus.stop_req = 1'b0;
    checks++; if (bus.at_brk !== 1'b0) $display("FAIL sh_at_brk: got %0b want 0", bus.at_brk); else passed++;
    checks++; if (bus.running !== 1'b0) $display("FAIL sh_running: got %0b want 0", bus.running); else passed++;
    checks++; if (bus.instr_cnt !== 32'd1) $display("FAIL sh_instr: got %0d want 1", bus.instr_cnt); else passed++;
    bus.brk_en = 1'b0;
  endtask

  task automatic test_priority();
    do_reset();
    bus.stop_req  = 1'b1;
    bus.istep_req = 1'b1;
    tick();
    bus.stop_req  = 1'b0;
    bus.istep_req = 1'b0;
    checks++; if (bus.running !== 1'b0) $display("FAIL prio_stop: got %0b want 0", bus.running); else passed++;
    tick();
    checks++; if (bus.cycle_cnt !== 32'd0) $display("FAIL prio_stop_cycle: got %0d want 0", bus.cycle_cnt); else passed++;
    bus.istep_req = 1'b1;
    bus.run_req   = 1'b1;
    tick();
    bus.istep_req = 1'b0;
    bus.run_req   = 1'b0;
    checks++; if (bus.running !== 1'b1) $display("FAIL prio_istep: got %0b want 1", bus.running); else passed++;
    repeat (4) tick();
    checks++; if (bus.running !== 1'b0) $display("FAIL prio_no_run: got %0b want 0", bus.running); else passed++;
    checks++; if (bus.cycle_cnt !== 32'd4) $display("FAIL prio_cycle: got %0d want 4", bus.cycle_cnt); else passed++;
    checks++; if (bus.instr_cnt !== 32'd1) $display("FAIL prio_instr: got %0d want 1", bus.instr_cnt); else passed++;
  endtask

  task automatic test_wrap_async_reset();
    do_reset();
    b4.run_req = 1'b1;
    tick();
    b4.run_req = 1'b0;
    repeat (17) tick();
    checks++; if (b4.cycle_cnt !== 4'd1) $display("FAIL wrap_cycle: got %0d want 1", b4.cycle_cnt); else passed++;
    checks++; if (b4.instr_cnt !== 4'd4) $display("FAIL wrap_instr: got %0d want 4", b4.instr_cnt); else passed++;
    checks++; if (b4.ph_cnt !== 2'd1) $display("FAIL wrap_ph: got %0d want 1", b4.ph_cnt); else passed++;
    checks++; if (b4.running !== 1'b1) $display("FAIL wrap_running: got %0b want 1", b4.running); else passed++;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (b4.cpu_en !== 1'b0) $display("FAIL arst_cpu_en: got %0b want 0", b4.cpu_en); else passed++;
    checks++; if (b4.cycle_cnt !== 4'd0) $display("FAIL arst_cycle: got %0d want 0", b4.cycle_cnt); else passed++;
    checks++; if (b4.instr_cnt !== 4'd0) $display("FAIL arst_instr: got %0d want 0", b4.instr_cnt); else passed++;
    checks++; if (b4.ph_cnt !== 2'd0) $display("FAIL arst_ph: got %0d want 0", b4.ph_cnt); else passed++;
    checks++; if (b4.running !== 1'b0) $display("FAIL arst_running: got %0b want 0", b4.running); else passed++;
    checks++; if (b4.at_brk !== 1'b0) $display("FAIL arst_at_brk: got %0b want 0", b4.at_brk); else passed++;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    checks        = 0;
    passed        = 0;
    reset         = 1'b1;
    bus.run_req   = 1'b0;
    bus.stop_req  = 1'b0;
    bus.cstep_req = 1'b0;
    bus.istep_req = 1'b0;
    bus.brk_en    = 1'b0;
    bus.brk_addr  = '0;
    b4.run_req    = 1'b0;
    b4.stop_req   = 1'b0;
    b4.cstep_req  = 1'b0;
    b4.istep_req  = 1'b0;
    b4.brk_en     = 1'b0;
    b4.brk_addr   = '0;
    tick();
    reset = 1'b0;

    test_reset();
    test_run_stop();
    test_single_steps();
    test_istep_stop();
    test_breakpoint();
    test_stop_and_hit();
    test_priority();
    test_wrap_async_reset();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
